sudoku_cmd_sequencer: RTL
=========================

Name: sudoku_cmd_sequencer

Overview:
- Sits between the five button conditioners and sudoku_engine. Replaces the ad-hoc mode/command glue.
- Owns the MOVE/NUMBER/LOCKED mode state machine and the selected-number register.
- Serialises button events into single-cycle engine commands through a one-entry pending slot gated by engine_ready.
- Generates the cursor flash enable for sudoku_draw. Optional auto-repeat for held direction buttons.

Parameters:
FLASH_BITS, 27, width of free-running flash counter; flash uses MSB
REPEAT_DELAY, 50000000, clk cycles a direction must be held before the first repeat (AUTOREPEAT_EN only)
REPEAT_PERIOD, 10000000, clk cycles between subsequent repeats (AUTOREPEAT_EN only)

Ports:
clk  in  1  100 MHz system clock
reset  in  1  asynchronous, active-high reset
btn_c_pulse, btn_u_pulse, btn_d_pulse, btn_l_pulse, btn_r_pulse  in  1 each  one-cycle conditioned press pulses
btn_u_level, btn_d_level, btn_l_level, btn_r_level  in  1 each  conditioned held levels
engine_ready  in  1  engine can accept a command this cycle
game_over  in  1  game_won | game_lost
cmd_up, cmd_down, cmd_left, cmd_right, cmd_enter  out  1 each  command strobes, valid only with cmd_valid
cmd_number  out  4  number for an enter command, else 0
cmd_valid  out  1  one-cycle command strobe
mode  out  2  0=MOVE, 1=NUMBER, 2=LOCKED
selected_number  out  4  current preview number, 1..9
flash_visible  out  1  cursor draw enable
drop_count  out  8  saturating count of events discarded while the slot was full

Behaviour:
- Reset (async, any time, including mid-command):
  - mode=MOVE, selected_number=1, pending slot empty.
  - All cmd_* = 0, flash counter = 0, drop_count = 0.
  - Repeat timers cleared.
- Event selection: at most one event per edge. Priority C > U > D > L > R. Lower-priority pulses in the same cycle are ignored and not counted as drops.
- MOVE state:
  - U/D/L/R: load the pending slot with the matching direction.
  - C: go to NUMBER. No command is issued.
- NUMBER state:
  - U: selected_number +1, wrapping 9 -> 1.
  - D: selected_number -1, wrapping 1 -> 9.
  - C: load pending with cmd_enter=1, cmd_number=selected_number, then return to MOVE.
  - L: cancel, return to MOVE with no command.
  - R: ignored.
  - U/D/L/R in this state never load the slot.
- LOCKED state:
  - Entered on any edge where game_over=1, from any state. This takes priority over a same-cycle event; that event is discarded and not counted.
  - Exits only via reset.
  - No slot loads. An already-pending command is still issued.
- selected_number is retained across mode changes.
- Pending slot and handshake:
  - An event accepted at edge k sets pending after edge k.
  - At the first edge j>k with engine_ready=1, the registered outputs present the command for exactly the cycle after edge j, and the slot clears.
  - The slot may accept a new event on the same edge it issues.
  - A slot-loading event arriving while the slot is full and not issuing is discarded, and drop_count increments (saturates at 255).
  - Mode and selected_number updates happen at acceptance regardless of slot state. The only exception is NUMBER+C with a full slot: it is dropped and the mode stays NUMBER.
- cmd_valid is never high on two consecutive cycles. Minimum issue latency is 2 edges from the pulse.
- Flash:
  - Counter free-runs and wraps.
  - flash_visible = counter[FLASH_BITS-1] in NUMBER, 1 otherwise.

Optional Feature:
- Macro SUDOKU_AUTOREPEAT_EN.
- Defined:
  - In MOVE, a direction level held continuously for REPEAT_DELAY cycles after its pulse generates a synthetic event of that direction.
  - Further synthetic events follow every REPEAT_PERIOD cycles while held.
  - Synthetic events have lowest priority and obey slot and drop rules.
  - The timer clears on level release, on a mode change, or when a different direction pulses.
- Undefined:
  - Levels are unused and no repeat logic is synthesised.
  - The behaviour is otherwise identical.

Test Plan:
- Reset asserted mid-pending (slot full, engine_ready=0) -> all outputs 0, mode=0, selected_number=1 within the same cycle (async).
- MOVE, engine_ready=1, btn_r_pulse at edge 10 -> cmd_right=cmd_valid=1 only in the cycle after edge 11.
- C, U x9, D x1, C with engine_ready=1 -> number wraps 1..9->1 then ->9; one enter with cmd_number=9; mode back to 0.
- engine_ready=0, pulses U then L then D -> one pending up; drop_count=2; ready=1 -> single cmd_up.
- game_over=1 same cycle as btn_u_pulse -> mode=2, no command, drop_count unchanged; later pulses ignored.
- SUDOKU_AUTOREPEAT_EN, REPEAT_DELAY=20, REPEAT_PERIOD=5, btn_l held 40 cycles, engine_ready=1 -> 1 pulse-driven + 4 repeat cmd_left strobes.

Source files
------------

// File: rtl/sudoku_cmd_sequencer.sv
// sudoku_cmd_sequencer: button events -> single-cycle engine commands via a one-entry slot, plus mode FSM and cursor flash.
// Define SUDOKU_AUTOREPEAT_EN to enable auto-repeat of held direction buttons in MOVE mode.
module sudoku_cmd_sequencer #(
    parameter int FLASH_BITS    = 27,
    parameter int REPEAT_DELAY  = 50000000,
    parameter int REPEAT_PERIOD = 10000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_c_pulse,
    input  logic       btn_u_pulse,
    input  logic       btn_d_pulse,
    input  logic       btn_l_pulse,
    input  logic       btn_r_pulse,
    input  logic       btn_u_level,
    input  logic       btn_d_level,
    input  logic       btn_l_level,
    input  logic       btn_r_level,
    input  logic       engine_ready,
    input  logic       game_over,
    output logic       cmd_up,
    output logic       cmd_down,
    output logic       cmd_left,
    output logic       cmd_right,
    output logic       cmd_enter,
    output logic [3:0] cmd_number,
    output logic       cmd_valid,
    output logic [1:0] mode,
    output logic [3:0] selected_number,
    output logic       flash_visible,
    output logic [7:0] drop_count
);
    typedef enum logic [1:0] {MOVE = 2'd0, NUMBER = 2'd1, LOCKED = 2'd2} mode_t;
    typedef enum logic [2:0] {E_NONE, E_C, E_U, E_D, E_L, E_R} evt_t;

    mode_t                 state;
    evt_t                  evt, syn_evt;
    logic                  pend, p_enter, issue, load_dir, load_ent, load, drop;
    logic [3:0]            p_dir, p_num;
    logic [FLASH_BITS-1:0] flash_cnt;

    assign mode          = state;
    assign flash_visible = state == NUMBER ? flash_cnt[FLASH_BITS-1] : 1'b1;

    // Back-to-back issue is blocked so cmd_valid never stays high for two cycles.
    always_comb begin
        evt = btn_c_pulse ? E_C : btn_u_pulse ? E_U : btn_d_pulse ? E_D :
              btn_l_pulse ? E_L : btn_r_pulse ? E_R : syn_evt;
        issue    = pend && engine_ready && !cmd_valid;
        load_dir = !game_over && state == MOVE && evt inside {E_U, E_D, E_L, E_R};
        load_ent = !game_over && state == NUMBER && evt == E_C;
        load     = (load_dir || load_ent) && (!pend || issue);
        drop     = (load_dir || load_ent) && pend && !issue;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= MOVE;
            selected_number <= 4'd1;
            pend            <= 1'b0;
            p_dir           <= 4'd0;
            p_enter         <= 1'b0;
            p_num           <= 4'd0;
            {cmd_up, cmd_down, cmd_left, cmd_right, cmd_enter, cmd_valid} <= 6'd0;
            cmd_number      <= 4'd0;
            flash_cnt       <= '0;
            drop_count      <= 8'd0;
        end else begin
            flash_cnt  <= flash_cnt + 1'b1;
            cmd_valid  <= issue;
            {cmd_up, cmd_down, cmd_left, cmd_right} <= issue ? p_dir : 4'd0;
            cmd_enter  <= issue && p_enter;
            cmd_number <= issue ? p_num : 4'd0;
            pend       <= load || (pend && !issue);
            if (load) begin
                p_dir   <= {evt == E_U, evt == E_D, evt == E_L, evt == E_R} & {4{load_dir}};
                p_enter <= load_ent;
                p_num   <= load_ent ? selected_number : 4'd0;
            end
            if (drop && drop_count != 8'hFF)
                drop_count <= drop_count + 8'd1;
            if (game_over)
                state <= LOCKED;
            else if (state == MOVE && evt == E_C)
                state <= NUMBER;
            else if (state == NUMBER && (evt == E_L || (evt == E_C && load)))
                state <= MOVE;
            if (!game_over && state == NUMBER && evt == E_U)
                selected_number <= selected_number == 4'd9 ? 4'd1 : selected_number + 4'd1;
            else if (!game_over && state == NUMBER && evt == E_D)
                selected_number <= selected_number == 4'd1 ? 4'd9 : selected_number - 4'd1;
        end
    end

`ifdef SUDOKU_AUTOREPEAT_EN
    logic        rep_on, held, fire, dir_pulse;
    logic [3:0]  rep_sel;
    logic [31:0] rep_cnt;

    assign held      = |(rep_sel & {btn_u_level, btn_d_level, btn_l_level, btn_r_level});
    assign fire      = rep_on && held && state == MOVE && rep_cnt == 32'(REPEAT_DELAY - 1);
    assign syn_evt   = !fire ? E_NONE : rep_sel[3] ? E_U : rep_sel[2] ? E_D : rep_sel[1] ? E_L : E_R;
    assign dir_pulse = !btn_c_pulse && (btn_u_pulse || btn_d_pulse || btn_l_pulse || btn_r_pulse);

    // A fresh direction pulse restarts the timer; after the first repeat it reloads to space repeats by REPEAT_PERIOD.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rep_on  <= 1'b0;
            rep_sel <= 4'd0;
            rep_cnt <= 32'd0;
        end else if (game_over || state != MOVE || btn_c_pulse) begin
            rep_on <= 1'b0;
        end else if (dir_pulse) begin
            rep_on  <= 1'b1;
            rep_sel <= {evt == E_U, evt == E_D, evt == E_L, evt == E_R};
            rep_cnt <= 32'd0;
        end else if (!held) begin
            rep_on <= 1'b0;
        end else if (fire) begin
            rep_cnt <= 32'(REPEAT_DELAY - REPEAT_PERIOD);
        end else begin
            rep_cnt <= rep_cnt + 32'd1;
        end
    end
`else
    logic unused_levels;
    assign syn_evt       = E_NONE;
    assign unused_levels = ^{btn_u_level, btn_d_level, btn_l_level, btn_r_level,
                             REPEAT_DELAY[0], REPEAT_PERIOD[0]};
`endif
endmodule
